// File: rtl/snappy_axi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : snappy_axi_pkg                                              |
// | Purpose    : Shared definitions for the snappy AXI read path: a clog2    |
// |              helper, default sizing constants shared with the AR         |
// |              arbiter, and the routing-FIFO entry record {sel, len}.      |
// | Ports      : none (package)                                             |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
package snappy_axi_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int C_DEFAULT_NUM_DECOMPRESSOR = 2;
  localparam int C_DEFAULT_DEPTH            = 8;
  localparam int C_DEFAULT_DEPTH_LOG2       = clog2(C_DEFAULT_DEPTH);
  localparam int C_DEFAULT_LEN_WIDTH        = 8;

  // Entry record at the default sizing, as seen by the AR arbiter.
  typedef struct packed {
    logic [C_DEFAULT_NUM_DECOMPRESSOR-1:0] sel;
    logic [C_DEFAULT_LEN_WIDTH-1:0]        len;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/axi_fifo_ptr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : axi_fifo_ptr_ctrl                                           |
// | Purpose    : Read/write pointer pair with wrap bit, occupancy count and  |
// |              full/empty flags for a 2**DEPTH_LOG2 entry FIFO.            |
// | Ports      : clk, rst_n     clock, synchronous active-low reset          |
// |              push, pop      requests (refused when full / empty)         |
// |              wr_idx, rd_idx array indices (pointer low bits)             |
// |              count          occupancy 0..DEPTH                           |
// |              full, empty    status from registered pointers              |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module axi_fifo_ptr_ctrl
  import snappy_axi_pkg::*;
#(
  parameter int DEPTH_LOG2 = C_DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  output logic [DEPTH_LOG2-1:0] wr_idx,
  output logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  // The extra MSB distinguishes "same slot, lapped" (full) from "same slot" (empty).
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_do_push;
  logic                w_do_pop;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                  (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign count  = r_wr_ptr - r_rd_ptr;
  assign wr_idx = r_wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx = r_rd_ptr[DEPTH_LOG2-1:0];

  // Full is judged on registered state, so a same-cycle pop never frees a slot.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_rd_order_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : axi_rd_order_fifo                                           |
// | Purpose    : In-order routing FIFO for the shared AXI read channel.      |
// |              Each AR push records {one-hot owner, arlen}; the head entry |
// |              steers R beats to its owner, counts beats and retires on    |
// |              the last beat. Burst-length and orphan-beat errors pulse.   |
// | Ports      : clk, rst_n                  clock, sync active-low reset    |
// |              push_valid/ready/sel/len    AR-side entry recording         |
// |              r_valid, r_last, r_ready    AXI R handshake                 |
// |              sel_ready, sel_out          per-decompressor steering       |
// |              head_valid, beat_cnt        head entry state                |
// |              count, full, empty,         occupancy status                |
// |              almost_full                                                 |
// |              err_len, err_orphan         registered error pulses         |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module axi_rd_order_fifo
  import snappy_axi_pkg::*;
#(
  parameter int NUM_DECOMPRESSOR = C_DEFAULT_NUM_DECOMPRESSOR,
  parameter int DEPTH_LOG2       = C_DEFAULT_DEPTH_LOG2,
  parameter int LEN_WIDTH        = C_DEFAULT_LEN_WIDTH,
  parameter int AF_LEVEL         = (2 ** DEPTH_LOG2) - 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_valid,
  output logic                        push_ready,
  input  logic [NUM_DECOMPRESSOR-1:0] push_sel,
  input  logic [LEN_WIDTH-1:0]        push_len,
  input  logic                        r_valid,
  input  logic                        r_last,
  output logic                        r_ready,
  input  logic [NUM_DECOMPRESSOR-1:0] sel_ready,
  output logic [NUM_DECOMPRESSOR-1:0] sel_out,
  output logic                        head_valid,
  output logic [LEN_WIDTH-1:0]        beat_cnt,
  output logic [DEPTH_LOG2:0]         count,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        err_len,
  output logic                        err_orphan
);

  localparam int                  C_DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_AF_LEVEL = AF_LEVEL[DEPTH_LOG2:0];

  typedef struct packed {
    logic [NUM_DECOMPRESSOR-1:0] sel;
    logic [LEN_WIDTH-1:0]        len;
  } entry_rec_t;

  entry_rec_t            r_mem [C_DEPTH];
  entry_rec_t            w_head;
  logic [DEPTH_LOG2-1:0] w_wr_idx;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic                  w_push;
  logic                  w_beat;
  logic                  w_pop;
  logic                  w_at_len;
  logic                  w_len_err;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;
  logic                  r_err_len;
  logic                  r_err_orphan;

  axi_fifo_ptr_ctrl #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ptr_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (w_push),
    .pop    (w_pop),
    .wr_idx (w_wr_idx),
    .rd_idx (w_rd_idx),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign w_push = push_valid & ~full;

  // Array contents need no reset: an entry is only read once it has been written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_idx] <= {push_sel, push_len};
  end

  // Steering depends only on registered state and sel_ready.
  assign w_head      = r_mem[w_rd_idx];
  assign head_valid  = ~empty;
  assign sel_out     = head_valid ? w_head.sel : '0;
  assign r_ready     = head_valid & (|(sel_ready & w_head.sel));
  assign push_ready  = ~full;
  assign almost_full = (count >= C_AF_LEVEL);

  assign w_beat    = r_valid & r_ready;
  assign w_pop     = w_beat & r_last;
  assign w_at_len  = (r_beat_cnt == w_head.len);
  assign w_len_err = w_beat & (r_last != w_at_len);

  // A burst that runs past its length parks beat_cnt at all-ones until rlast retires it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat_cnt   <= '0;
      r_err_len    <= 1'b0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_pop) begin
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        if (w_len_err || (&r_beat_cnt)) r_beat_cnt <= '1;
        else                            r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      r_err_len    <= w_len_err;
      r_err_orphan <= r_valid & empty;
    end
  end

  assign beat_cnt   = r_beat_cnt;
  assign err_len    = r_err_len;
  assign err_orphan = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_order_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_axi_rd_order_fifo                                        |
// | Purpose    : Self-checking bench for axi_rd_order_fifo: vector table,    |
// |              directed corner sequences and a queue-based random model.   |
// | Ports      : none                                                       |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module tb_axi_rd_order_fifo;

  logic       clk;
  logic       rst_n;
  logic       push_valid;
  logic       push_ready;
  logic [1:0] push_sel;
  logic [7:0] push_len;
  logic       r_valid;
  logic       r_last;
  logic       r_ready;
  logic [1:0] sel_ready;
  logic [1:0] sel_out;
  logic       head_valid;
  logic [7:0] beat_cnt;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       err_len;
  logic       err_orphan;

  int n_checks = 0;
  int n_fail   = 0;

  axi_rd_order_fifo #(
    .NUM_DECOMPRESSOR (2),
    .DEPTH_LOG2       (3),
    .LEN_WIDTH        (8),
    .AF_LEVEL         (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_sel    (push_sel),
    .push_len    (push_len),
    .r_valid     (r_valid),
    .r_last      (r_last),
    .r_ready     (r_ready),
    .sel_ready   (sel_ready),
    .sel_out     (sel_out),
    .head_valid  (head_valid),
    .beat_cnt    (beat_cnt),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .err_len     (err_len),
    .err_orphan  (err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid = 1'b0;
    push_sel   = 2'b00;
    push_len   = 8'd0;
    r_valid    = 1'b0;
    r_last     = 1'b0;
    sel_ready  = 2'b11;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_one(input logic [1:0] s, input logic [7:0] l);
    push_valid = 1'b1;
    push_sel   = s;
    push_len   = l;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    chk({tag, " push_ready"}, push_ready, 1);
    chk({tag, " empty"}, empty, 1);
    chk({tag, " full"}, full, 0);
    chk({tag, " almost_full"}, almost_full, 0);
    chk({tag, " count"}, count, 0);
    chk({tag, " head_valid"}, head_valid, 0);
    chk({tag, " sel_out"}, sel_out, 0);
    chk({tag, " r_ready"}, r_ready, 0);
    chk({tag, " beat_cnt"}, beat_cnt, 0);
    chk({tag, " err_len"}, err_len, 0);
    chk({tag, " err_orphan"}, err_orphan, 0);
  endtask

  typedef struct {
    logic       pv;
    logic [1:0] psel;
    logic [7:0] plen;
    logic       rv;
    logic       rl;
    logic [1:0] srdy;
    int         e_count;
    logic [1:0] e_sel;
    logic       e_rr;
    logic [7:0] e_bc;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] len;
  } ent_t;

  vec_t vecs[$];
  ent_t q[$];

  initial begin
    idle();
    rst_n = 1'b0;

    // ---------------- reset state ----------------
    do_reset();
    check_reset_state("reset");

    // ---------------- vector table: 4 bursts, 1+4+2+1 beats ----------------
    //                pv  psel   plen  rv  rl  srdy   cnt sel   rr bc
    vecs.push_back('{1'b1, 2'b01, 8'd0, 1'b0, 1'b0, 2'b11, 0, 2'b00, 1'b0, 8'd0});
    vecs.push_back('{1'b1, 2'b10, 8'd3, 1'b0, 1'b0, 2'b11, 1, 2'b01, 1'b1, 8'd0});
    vecs.push_back('{1'b1, 2'b01, 8'd1, 1'b0, 1'b0, 2'b11, 2, 2'b01, 1'b1, 8'd0});
    vecs.push_back('{1'b1, 2'b10, 8'd0, 1'b0, 1'b0, 2'b11, 3, 2'b01, 1'b1, 8'd0});
    vecs.push_back('{1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 2'b11, 4, 2'b01, 1'b1, 8'd0});
    vecs.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 2'b11, 4, 2'b01, 1'b1, 8'd0});
    vecs.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b01, 3, 2'b10, 1'b0, 8'd0});
    vecs.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11, 3, 2'b10, 1'b1, 8'd0});
    vecs.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11, 3, 2'b10, 1'b1, 8'd1});
    vecs.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11, 3, 2'b10, 1'b1, 8'd2});
    vecs.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 2'b11, 3, 2'b10, 1'b1, 8'd3});
    vecs.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 2'b11, 2, 2'b01, 1'b1, 8'd0});
    vecs.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 2'b11, 2, 2'b01, 1'b1, 8'd1});
    vecs.push_back('{1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 2'b11, 1, 2'b10, 1'b1, 8'd0});
    vecs.push_back('{1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 2'b11, 0, 2'b00, 1'b0, 8'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      push_valid = vecs[i].pv;
      push_sel   = vecs[i].psel;
      push_len   = vecs[i].plen;
      r_valid    = vecs[i].rv;
      r_last     = vecs[i].rl;
      sel_ready  = vecs[i].srdy;
      #1;
      chk($sformatf("vec%0d count", i), count, vecs[i].e_count);
      chk($sformatf("vec%0d sel_out", i), sel_out, vecs[i].e_sel);
      chk($sformatf("vec%0d r_ready", i), r_ready, vecs[i].e_rr);
      chk($sformatf("vec%0d beat_cnt", i), beat_cnt, vecs[i].e_bc);
      chk($sformatf("vec%0d empty", i), empty, (vecs[i].e_count == 0));
      chk($sformatf("vec%0d err_len", i), err_len, 0);
      chk($sformatf("vec%0d err_orphan", i), err_orphan, 0);
      tick();
    end
    idle();

    // ---------------- fill to full, refused pushes ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("fill%0d count", i), count, i);
      chk($sformatf("fill%0d almost_full", i), almost_full, (i >= 6));
      chk($sformatf("fill%0d full", i), full, 0);
      push_one((i % 2 == 1) ? 2'b10 : 2'b01, 8'd0);
    end
    #1;
    chk("full count", count, 8);
    chk("full flag", full, 1);
    chk("full push_ready", push_ready, 0);
    chk("full almost_full", almost_full, 1);
    push_one(2'b01, 8'd0);
    #1;
    chk("ninth push count", count, 8);
    // push + pop together while full: push is refused
    push_valid = 1'b1; push_sel = 2'b10; push_len = 8'd5;
    r_valid = 1'b1; r_last = 1'b1;
    #1;
    chk("full pop r_ready", r_ready, 1);
    tick();
    idle();
    #1;
    chk("after full push+pop count", count, 7);
    chk("after full push+pop full", full, 0);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("drain%0d sel_out", i), sel_out, (i % 2 == 1) ? 2'b10 : 2'b01);
      r_valid = 1'b1; r_last = 1'b1;
      tick();
      r_valid = 1'b0; r_last = 1'b0;
      #1;
    end
    chk("drain count", count, 0);
    chk("drain empty", empty, 1);
    chk("drain err_len", err_len, 0);

    // ---------------- early rlast on len=3 ----------------
    do_reset();
    push_one(2'b01, 8'd3);
    push_one(2'b10, 8'd0);
    r_valid = 1'b1; r_last = 1'b0;
    tick();
    tick();
    r_last = 1'b1;
    #1;
    chk("early beat_cnt", beat_cnt, 2);
    tick();
    r_valid = 1'b0; r_last = 1'b0;
    #1;
    chk("early err_len", err_len, 1);
    chk("early count", count, 1);
    chk("early next sel_out", sel_out, 2'b10);
    chk("early beat_cnt reset", beat_cnt, 0);
    tick();
    chk("early err_len clears", err_len, 0);

    // ---------------- missing rlast on len=1 ----------------
    push_valid = 1'b1; push_sel = 2'b01; push_len = 8'd1;
    r_valid = 1'b1; r_last = 1'b1;
    tick();
    push_valid = 1'b0;
    r_last = 1'b0;
    #1;
    chk("late head sel_out", sel_out, 2'b01);
    tick();
    #1;
    chk("late beat1 err_len", err_len, 0);
    chk("late beat1 beat_cnt", beat_cnt, 1);
    tick();
    r_valid = 1'b0;
    #1;
    chk("late err_len", err_len, 1);
    chk("late beat_cnt sat", beat_cnt, 8'hff);
    chk("late count", count, 1);
    tick();
    chk("late err_len clears", err_len, 0);

    // ---------------- orphan beat ----------------
    do_reset();
    r_valid = 1'b1; r_last = 1'b0;
    #1;
    chk("orphan r_ready", r_ready, 0);
    chk("orphan head_valid", head_valid, 0);
    tick();
    r_valid = 1'b0;
    #1;
    chk("orphan err_orphan", err_orphan, 1);
    tick();
    chk("orphan clears", err_orphan, 0);

    // ---------------- reset mid-burst ----------------
    do_reset();
    push_one(2'b01, 8'd3);
    for (int i = 0; i < 4; i++) push_one(2'b10, 8'd0);
    r_valid = 1'b1; r_last = 1'b0;
    tick();
    tick();
    r_valid = 1'b0;
    #1;
    chk("midburst count", count, 5);
    chk("midburst beat_cnt", beat_cnt, 2);
    rst_n = 1'b0;
    tick();
    check_reset_state("midburst reset");
    rst_n = 1'b1;

    // ---------------- randomized against queue model ----------------
    do_reset();
    begin
      int  m_bc;
      bit  exp_err_len;
      bit  exp_err_orph;
      bit  hv;
      bit  exp_rr;
      bit  beat;
      bit  n_err_len;
      bit  n_err_orph;
      int  push_pct;
      int  r_pct;
      ent_t e;
      q.delete();
      m_bc = 0;
      exp_err_len = 0;
      exp_err_orph = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        push_pct = (cyc < 200) ? 70 : 30;
        r_pct    = (cyc < 200) ? 40 : 80;
        push_valid = ($urandom_range(0, 99) < push_pct);
        push_sel   = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        push_len   = 8'($urandom_range(0, 3));
        r_valid    = ($urandom_range(0, 99) < r_pct);
        sel_ready  = 2'($urandom_range(0, 3));
        if (q.size() != 0) begin
          if (m_bc == 255) r_last = 1'b1;
          else begin
            r_last = (m_bc == int'(q[0].len));
            if ($urandom_range(0, 15) == 0) r_last = ~r_last;
          end
        end else begin
          r_last = 1'($urandom_range(0, 1));
        end
        #1;
        hv     = (q.size() != 0);
        exp_rr = hv && ((sel_ready & q[0].sel) != 2'b00);
        chk("rnd count", count, q.size());
        chk("rnd head_valid", head_valid, hv);
        chk("rnd sel_out", sel_out, hv ? q[0].sel : 2'b00);
        chk("rnd r_ready", r_ready, exp_rr);
        chk("rnd beat_cnt", beat_cnt, m_bc);
        chk("rnd full", full, (q.size() == 8));
        chk("rnd empty", empty, (q.size() == 0));
        chk("rnd almost_full", almost_full, (q.size() >= 6));
        chk("rnd push_ready", push_ready, (q.size() != 8));
        chk("rnd err_len", err_len, exp_err_len);
        chk("rnd err_orphan", err_orphan, exp_err_orph);
        beat       = r_valid && exp_rr;
        n_err_len  = beat && (r_last != (m_bc == int'(q[0].len)));
        n_err_orph = r_valid && (q.size() == 0);
        e.sel = push_sel;
        e.len = push_len;
        if (push_valid && q.size() < 8) begin
          if (beat) begin
            if (r_last) begin
              void'(q.pop_front());
              m_bc = 0;
            end else if (m_bc == int'(q[0].len) || m_bc == 255) m_bc = 255;
            else m_bc = m_bc + 1;
          end
          q.push_back(e);
        end else if (beat) begin
          if (r_last) begin
            void'(q.pop_front());
            m_bc = 0;
          end else if (m_bc == int'(q[0].len) || m_bc == 255) m_bc = 255;
          else m_bc = m_bc + 1;
        end
        exp_err_len  = n_err_len;
        exp_err_orph = n_err_orph;
        tick();
      end
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_rd_order_fifo.md
# axi_rd_order_fifo

In-order routing FIFO for the shared AXI read channel in front of the decompressor array. Each accepted AR request pushes the issuing decompressor's one-hot select and its burst length. The head entry steers R beats to that decompressor, counts beats, and retires the entry on the burst's last beat. This replaces the fixed 8-entry select FIFO: depth is a parameter, all entries are usable, the block tracks occupancy, and it checks burst length.

## Interface
Parameters:
- NUM_DECOMPRESSOR, 2, width of the one-hot select vector
- DEPTH_LOG2, 3, log2 of entry count; DEPTH = 2**DEPTH_LOG2, all DEPTH entries usable
- LEN_WIDTH, 8, width of burst length field (AXI arlen encoding, beats-1)
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL

Ports (reset rst_n, synchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- push_valid  in  1  AR handshake completed; record an entry
- push_ready  out  1  entry can be accepted (= ~full)
- push_sel  in  NUM_DECOMPRESSOR  one-hot owner of the request
- push_len  in  LEN_WIDTH  arlen of the request
- r_valid  in  1  AXI R beat present
- r_last  in  1  AXI rlast
- r_ready  out  1  R beat accepted (= head_valid & sel_ready[head owner])
- sel_ready  in  NUM_DECOMPRESSOR  per-decompressor ready for R data
- sel_out  out  NUM_DECOMPRESSOR  head owner select; 0 when empty
- head_valid  out  1  FIFO non-empty
- beat_cnt  out  LEN_WIDTH  beats already accepted for head burst
- count  out  DEPTH_LOG2+1  occupancy 0..DEPTH
- full, empty, almost_full  out  1  status
- err_len  out  1  one-cycle pulse on burst-length mismatch
- err_orphan  out  1  one-cycle pulse on R beat while empty

## Operation
- Pointers are DEPTH_LOG2+1 bits wide, with the extra bit used for wrap. empty = (wr_ptr == rd_ptr). full = MSBs differ and the low bits are equal. count = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1).
- push = push_valid & ~full. The block writes {push_sel, push_len} at wr_ptr[DEPTH_LOG2-1:0] and increments wr_ptr. push_valid while full is dropped and has no state effect.
- beat = r_valid & r_ready. A beat increments beat_cnt. On beat & r_last the block pops: rd_ptr increments and beat_cnt returns to 0.
- err_len pulses the cycle after a beat where r_last != (beat_cnt == head_len). On a mismatch with r_last the entry still pops. On a mismatch without r_last, beat_cnt saturates at all-ones.
- err_orphan pulses the cycle after r_valid & empty. r_ready is 0 in that case.
- sel_out, r_ready, head_valid and full/empty are combinational from registered state and sel_ready only. There is no path from push_valid or r_valid to any output.
- Simultaneous push and pop: both occur and count is unchanged. When full, push is refused even if a pop happens in the same cycle (no bypass). When empty, a push is not visible to the R side until the next cycle.
- Reset, including mid-burst, clears pointers, beat_cnt and error flags. Array contents are don't-care. Outstanding AXI bursts are the caller's responsibility.
- Reset values: push_ready=1, empty=1, full=0, almost_full=0 (for AF_LEVEL>0), count=0, head_valid=0, sel_out=0, r_ready=0, beat_cnt=0, err_len=0, err_orphan=0.

## Timing
- Push-to-head latency is 1 cycle: an entry pushed at edge N can drive sel_out and r_ready in cycle N+1.
- Pop-to-next-head latency is 0 cycles: the next entry is presented in the cycle after the rlast beat, so back-to-back bursts need no bubble.
- Status outputs update in the cycle after the causing edge.
- err_len and err_orphan are registered, giving 1-cycle latency.

## Structure
- Shared package snappy_axi_pkg holds: clog2 helper, entry record type {sel, len}, and default DEPTH_LOG2/LEN_WIDTH constants reused by the AR arbiter.
- One sub-module, axi_fifo_ptr_ctrl, owns the pointer, count and full/empty logic, parameterised on DEPTH_LOG2. The top level holds the entry array, beat counter, steering and error logic.

## Test plan
- Reset, then push 4 entries (sel 01,10,01,10; len 0,3,1,0) -> count=4; R stream of 1+4+2+1 beats with correct rlast -> sel_out sequence 01,10,01,10, no errors, empty at end.
- Fill to DEPTH=8 -> full=1, push_ready=0; a ninth push is ignored; push and pop in the same cycle while full -> count goes 8→7, pushed entry lost.
- Wrap-around: 20 push/pop cycles at depth 8 with random len -> order preserved and count matches a reference model throughout.
- Head len=3 with rlast on beat 2 -> err_len pulse, entry popped, next owner presented the following cycle. Len=1 with no rlast after 2 beats -> err_len pulse.
- r_valid=1 while empty -> r_ready=0, err_orphan pulses one cycle later.
- Assert rst_n mid-burst with count=5 and beat_cnt=2 -> next cycle count=0, beat_cnt=0, all outputs at reset values.
